// File: rtl/datapath16_core_pkg.sv
// Shared constants, instruction field positions and ALU decode helpers for datapath16_core.
package datapath16_core_pkg;

    localparam int unsigned DataWidth    = 16;
    localparam int unsigned NumRegs      = 8;
    localparam int unsigned RegAddrWidth = 3;
    localparam int unsigned ImmWidth     = 8;
    localparam int unsigned FunctWidth   = 5;

    localparam int unsigned OpcodeMsb = 15;
    localparam int unsigned OpcodeLsb = 14;
    localparam int unsigned RsMsb     = 13;
    localparam int unsigned RsLsb     = 11;
    localparam int unsigned RtMsb     = 10;
    localparam int unsigned RtLsb     = 8;
    localparam int unsigned RdMsb     = 7;
    localparam int unsigned RdLsb     = 5;
    localparam int unsigned FunctMsb  = 4;
    localparam int unsigned FunctLsb  = 0;
    localparam int unsigned ImmMsb    = 7;
    localparam int unsigned ImmLsb    = 0;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [FunctWidth-1:0] FUNCT_ADD = 5'd0;
    localparam logic [FunctWidth-1:0] FUNCT_SUB = 5'd1;
    localparam logic [FunctWidth-1:0] FUNCT_AND = 5'd2;
    localparam logic [FunctWidth-1:0] FUNCT_OR  = 5'd3;
    localparam logic [FunctWidth-1:0] FUNCT_SLT = 5'd4;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_fn_e;

    // alu_op 2'b11 and unknown funct codes both fall back to add.
    function automatic alu_fn_e decode_alu_fn(input logic [1:0]            alu_op,
                                              input logic [FunctWidth-1:0] funct);
        alu_fn_e fn;
        fn = AluAdd;
        case (alu_op)
            ALU_OP_ADD: fn = AluAdd;
            ALU_OP_SUB: fn = AluSub;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: fn = AluAdd;
                    FUNCT_SUB: fn = AluSub;
                    FUNCT_AND: fn = AluAnd;
                    FUNCT_OR:  fn = AluOr;
                    FUNCT_SLT: fn = AluSlt;
                    default:   fn = AluAdd;
                endcase
            end
            default: fn = AluAdd;
        endcase
        return fn;
    endfunction

    function automatic logic [DataWidth-1:0] sign_extend_imm(input logic [ImmWidth-1:0] imm);
        return {{(DataWidth - ImmWidth){imm[ImmWidth-1]}}, imm};
    endfunction

endpackage

// File: rtl/datapath16_core_alu.sv
// Combinational 16-bit ALU: add/sub/and/or/slt with zero and signed-overflow flags.
module datapath16_core_alu
    import datapath16_core_pkg::*;
(
    input  logic [1:0]            alu_op_i,
    input  logic [FunctWidth-1:0] funct_i,
    input  logic [DataWidth-1:0]  a_i,
    input  logic [DataWidth-1:0]  b_i,
    output logic [DataWidth-1:0]  result_o,
    output logic                  zero_o,
    output logic                  overflow_o
);

    alu_fn_e              fn;
    logic [DataWidth-1:0] sum;
    logic [DataWidth-1:0] diff;

    always_comb begin
        fn         = decode_alu_fn(alu_op_i, funct_i);
        sum        = a_i + b_i;
        diff       = a_i - b_i;
        result_o   = sum;
        overflow_o = 1'b0;
        case (fn)
            AluAdd: begin
                result_o   = sum;
                overflow_o = (a_i[DataWidth-1] == b_i[DataWidth-1]) &&
                             (sum[DataWidth-1] != a_i[DataWidth-1]);
            end
            AluSub: begin
                result_o   = diff;
                overflow_o = (a_i[DataWidth-1] != b_i[DataWidth-1]) &&
                             (diff[DataWidth-1] != a_i[DataWidth-1]);
            end
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluSlt:  result_o = {{(DataWidth - 1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = sum;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/datapath16_core_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port, R0 hardwired to 0.
module datapath16_core_regfile
    import datapath16_core_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [RegAddrWidth-1:0] raddr_a_i,
    input  logic [RegAddrWidth-1:0] raddr_b_i,
    input  logic                    we_i,
    input  logic [RegAddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic [DataWidth-1:0]    rdata_a_o,
    output logic [DataWidth-1:0]    rdata_b_o
);

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    // Reads see regs_q, so a same-cycle write is only visible after the edge.
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
        rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/datapath16_core.sv
// Single-cycle 16-bit datapath: PC, instruction/data memories, register file, ALU and write-back.
module datapath16_core
    import datapath16_core_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_load,
    input  logic [DataWidth-1:0] pc_in,
    input  logic                 imem_we,
    input  logic [7:0]           imem_waddr,
    input  logic [DataWidth-1:0] imem_wdata,
    input  logic                 reg_dest,
    input  logic                 alu_src,
    input  logic                 mem_to_reg,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           alu_op,
    output logic [1:0]           opcode,
    output logic [DataWidth-1:0] pc,
    output logic [DataWidth-1:0] instr,
    output logic [DataWidth-1:0] alu_result,
    output logic                 zero,
    output logic                 overflow,
    output logic [DataWidth-1:0] wb_data
);

    logic [DataWidth-1:0] pc_q;
    logic [DataWidth-1:0] pc_d;
    logic [DataWidth-1:0] imem_q [IMEM_DEPTH];
    logic [DataWidth-1:0] dmem_q [DMEM_DEPTH];

    logic [RegAddrWidth-1:0] rs_addr;
    logic [RegAddrWidth-1:0] rt_addr;
    logic [RegAddrWidth-1:0] rd_addr;
    logic [RegAddrWidth-1:0] wr_addr;
    logic [FunctWidth-1:0]   funct;
    logic [DataWidth-1:0]    imm_ext;
    logic [DataWidth-1:0]    rs_data;
    logic [DataWidth-1:0]    rt_data;
    logic [DataWidth-1:0]    alu_b;
    logic [DataWidth-1:0]    dmem_rdata;
    logic [7:0]              dmem_addr;

    always_comb begin
        pc_d = pc_load ? pc_in : pc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // The loader port is deliberately independent of reset and execution.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        instr   = imem_q[pc_q[7:0]];
        opcode  = instr[OpcodeMsb:OpcodeLsb];
        rs_addr = instr[RsMsb:RsLsb];
        rt_addr = instr[RtMsb:RtLsb];
        rd_addr = instr[RdMsb:RdLsb];
        funct   = instr[FunctMsb:FunctLsb];
        imm_ext = sign_extend_imm(instr[ImmMsb:ImmLsb]);
        wr_addr = reg_dest ? rd_addr : rt_addr;
        alu_b   = alu_src ? imm_ext : rt_data;
    end

    datapath16_core_regfile u_regfile (
        .clk_i     (clk),
        .reset_i   (reset),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .we_i      (reg_write),
        .waddr_i   (wr_addr),
        .wdata_i   (wb_data),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    datapath16_core_alu u_alu (
        .alu_op_i   (alu_op),
        .funct_i    (funct),
        .a_i        (rs_data),
        .b_i        (alu_b),
        .result_o   (alu_result),
        .zero_o     (zero),
        .overflow_o (overflow)
    );

    always_comb begin
        dmem_addr  = alu_result[7:0];
        dmem_rdata = mem_read ? dmem_q[dmem_addr] : '0;
        wb_data    = mem_to_reg ? dmem_rdata : alu_result;
        pc         = pc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_write) begin
            dmem_q[dmem_addr] <= rt_data;
        end
    end

endmodule

// File: tb/tb_datapath16_core.sv
// Scoreboard bench for datapath16_core: directed program plus randomized cycles against an integer model.
module tb_datapath16_core;

    logic        clk = 1'b0;
    logic        reset, pc_load, imem_we, reg_dest, alu_src, mem_to_reg;
    logic        reg_write, mem_read, mem_write;
    logic [15:0] pc_in, imem_wdata;
    logic [7:0]  imem_waddr;
    logic [1:0]  alu_op;
    logic [1:0]  opcode;
    logic [15:0] pc, instr, alu_result, wb_data;
    logic        zero, overflow;

    always #5 clk = ~clk;

    datapath16_core dut (
        .clk        (clk),
        .reset      (reset),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .reg_dest   (reg_dest),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .opcode     (opcode),
        .pc         (pc),
        .instr      (instr),
        .alu_result (alu_result),
        .zero       (zero),
        .overflow   (overflow),
        .wb_data    (wb_data)
    );

    typedef struct {
        bit reset; bit pc_load; int pc_in;
        bit imem_we; int imem_waddr; int imem_wdata;
        bit reg_dest; bit alu_src; bit mem_to_reg; bit reg_write;
        bit mem_read; bit mem_write; int alu_op;
    } stim_t;

    typedef struct {
        int pc; int instr; int opcode; int alu; int zero; int ovf; int wb;
        bit hc; int cw; int co;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state kept as plain integers.
    int m_pc;
    int m_imem[256];
    int m_dmem[256];
    bit m_dw[256];
    int m_regs[8];

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t c_i();
        stim_t s;
        s = idle();
        s.alu_src   = 1;
        s.reg_write = 1;
        return s;
    endfunction

    function automatic stim_t c_r();
        stim_t s;
        s = idle();
        s.reg_dest  = 1;
        s.alu_op    = 2;
        s.reg_write = 1;
        return s;
    endfunction

    function automatic int enc_i(input int rs, input int rt, input int imm);
        return (1 << 14) | (rs << 11) | (rt << 8) | (imm & 255);
    endfunction

    function automatic int enc_r(input int rs, input int rt, input int rd, input int funct);
        return (rs << 11) | (rt << 8) | (rd << 5) | funct;
    endfunction

    function automatic int to_s(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void model_eval(input stim_t s, output exp_t e);
        int ins, rs, rt, funct, imm, a, b, sa, sb, r, kind;
        ins   = m_imem[m_pc % 256];
        rs    = (ins >> 11) & 7;
        rt    = (ins >> 8) & 7;
        funct = ins & 31;
        imm   = ins & 255;
        a     = m_regs[rs];
        b     = s.alu_src ? ((imm >= 128) ? imm - 256 + 65536 : imm) : m_regs[rt];
        sa    = to_s(a);
        sb    = to_s(b);
        kind  = 0;
        if (s.alu_op == 1) kind = 1;
        else if (s.alu_op == 2 && funct >= 1 && funct <= 4) kind = funct;
        case (kind)
            1:       r = sa - sb;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = (sa < sb) ? 1 : 0;
            default: r = sa + sb;
        endcase
        e        = '{default: 0};
        e.pc     = m_pc;
        e.instr  = ins;
        e.opcode = ins >> 14;
        e.ovf    = (kind <= 1 && (r > 32767 || r < -32768)) ? 1 : 0;
        e.alu    = r & 65535;
        e.zero   = (e.alu == 0) ? 1 : 0;
        e.wb     = s.mem_to_reg ? (s.mem_read ? m_dmem[e.alu % 256] : 0) : e.alu;
        e.co     = -1;
    endfunction

    function automatic void model_commit(input stim_t s);
        exp_t e;
        int   ins, rt, rd, rt_val, wa;
        model_eval(s, e);
        ins    = m_imem[m_pc % 256];
        rt     = (ins >> 8) & 7;
        rd     = (ins >> 5) & 7;
        rt_val = m_regs[rt];
        if (s.imem_we) m_imem[s.imem_waddr % 256] = s.imem_wdata & 65535;
        if (s.reset) begin
            m_pc = 0;
            foreach (m_regs[i]) m_regs[i] = 0;
        end else begin
            wa = s.reg_dest ? rd : rt;
            if (s.reg_write && wa != 0) m_regs[wa] = e.wb;
            if (s.mem_write) begin
                m_dmem[e.alu % 256] = rt_val;
                m_dw[e.alu % 256]   = 1;
            end
            m_pc = s.pc_load ? (s.pc_in & 65535) : (m_pc + 1) % 65536;
        end
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
        end
    endtask

    // Drive at posedge+1, queue the model's expectation, then let the edge commit it.
    task automatic step(input stim_t s, input bit chk, input bit hc, input int cw, input int co);
        exp_t e;
        reset      = s.reset;
        pc_load    = s.pc_load;
        pc_in      = 16'(s.pc_in);
        imem_we    = s.imem_we;
        imem_waddr = 8'(s.imem_waddr);
        imem_wdata = 16'(s.imem_wdata);
        reg_dest   = s.reg_dest;
        alu_src    = s.alu_src;
        mem_to_reg = s.mem_to_reg;
        reg_write  = s.reg_write;
        mem_read   = s.mem_read;
        mem_write  = s.mem_write;
        alu_op     = 2'(s.alu_op);
        model_eval(s, e);
        e.hc = hc;
        e.cw = cw;
        e.co = co;
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        model_commit(s);
        #1;
    endtask

    // Park the instruction at the current pc (holding pc), then execute it.
    task automatic run(input int ins, input stim_t c, input int cw, input int co);
        stim_t w;
        w            = idle();
        w.imem_we    = 1;
        w.imem_waddr = m_pc % 256;
        w.imem_wdata = ins;
        w.pc_load    = 1;
        w.pc_in      = m_pc;
        step(w, 1, 0, 0, -1);
        step(c, 1, 1, cw, co);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("pc", pc, 16'(mon_e.pc));
            cmp("instr", instr, 16'(mon_e.instr));
            cmp("opcode", {14'b0, opcode}, 16'(mon_e.opcode));
            cmp("alu_result", alu_result, 16'(mon_e.alu));
            cmp("zero", {15'b0, zero}, 16'(mon_e.zero));
            cmp("overflow", {15'b0, overflow}, 16'(mon_e.ovf));
            cmp("wb_data", wb_data, 16'(mon_e.wb));
            if (mon_e.hc) cmp("wb_const", wb_data, 16'(mon_e.cw));
            if (mon_e.co >= 0) cmp("ovf_const", {15'b0, overflow}, 16'(mon_e.co));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, c;
        exp_t  e;
        m_pc = 0;
        foreach (m_regs[i]) m_regs[i] = 0;
        foreach (m_dw[i]) m_dw[i] = 0;

        // Fill instruction memory while held in reset.
        for (int i = 0; i < 256; i++) begin
            s            = idle();
            s.reset      = 1;
            s.imem_we    = 1;
            s.imem_waddr = i;
            s.imem_wdata = int'($urandom_range(0, 65535));
            step(s, 0, 0, 0, -1);
        end
        s       = idle();
        s.reset = 1;
        s.pc_load = 1;
        s.pc_in = 16'h1234;
        step(s, 1, 0, 0, -1);

        // pc counts, loads, and wraps.
        for (int i = 0; i < 4; i++) step(idle(), 1, 0, 0, -1);
        s = idle(); s.pc_load = 1; s.pc_in = 16'h0010;
        step(s, 1, 0, 0, -1);
        step(idle(), 1, 0, 0, -1);
        s = idle(); s.pc_load = 1; s.pc_in = 16'hFFFF;
        step(s, 1, 0, 0, -1);
        step(idle(), 1, 0, 0, -1);
        step(idle(), 1, 0, 0, -1);

        // I-type and R-type arithmetic.
        run(16'h4105, c_i(), 16'h0005, 0);
        run(16'h42FE, c_i(), 16'hFFFE, 0);
        run(16'h0A60, c_r(), 16'h0003, 0);
        run(16'h0A81, c_r(), 16'h0007, 0);
        run(16'h11A4, c_r(), 16'h0001, 0);

        // Build 0x7FFF in R1 by doubling, then overflow it.
        run(enc_i(0, 7, 1), c_i(), 1, 0);
        for (int k = 1; k < 16; k++) run(enc_r(7, 7, 7, 0), c_r(), 1 << k, (k == 15) ? 1 : 0);
        run(enc_i(7, 1, 8'hFF), c_i(), 16'h7FFF, 1);
        c = c_i(); c.reg_write = 0;
        run(enc_i(1, 2, 1), c, 16'h8000, 1);
        run(enc_r(1, 1, 3, 1), c_r(), 16'h0000, 0);

        // Store/load through data memory.
        run(enc_i(0, 1, 5), c_i(), 5, 0);
        run(enc_i(0, 2, 8'h12), c_i(), 16'h0012, 0);
        for (int k = 1; k <= 8; k++) run(enc_r(2, 2, 2, 0), c_r(), 16'h0012 << k, 0);
        run(enc_i(2, 2, 8'h34), c_i(), 16'h1234, 0);
        c = idle(); c.alu_src = 1; c.mem_write = 1;
        run(enc_i(1, 2, 3), c, 16'h0008, 0);
        c = c_i(); c.mem_read = 1; c.mem_to_reg = 1;
        run(enc_i(1, 3, 3), c, 16'h1234, -1);
        run(enc_r(3, 0, 4, 3), c_r(), 16'h1234, 0);
        c = c_i(); c.mem_to_reg = 1; c.reg_write = 0;
        run(enc_i(1, 3, 3), c, 16'h0000, -1);

        // R0 ignores writes.
        run(enc_i(0, 0, 7), c_i(), 7, 0);
        c = c_r(); c.reg_write = 0;
        run(enc_r(0, 0, 4, 0), c, 0, 0);

        // Mid-program reset clears registers and pc, keeps imem.
        s = idle(); s.reset = 1; s.pc_load = 1; s.pc_in = 16'h0040;
        s.reg_write = 1; s.mem_write = 1;
        step(s, 1, 0, 0, -1);
        step(idle(), 1, 0, 0, -1);
        run(enc_r(1, 2, 5, 3), c_r(), 0, 0);
        run(enc_r(3, 4, 6, 3), c_r(), 0, 0);
        run(enc_r(6, 7, 5, 3), c_r(), 0, 0);

        // Randomized cycles.
        for (int n = 0; n < 3000; n++) begin
            s            = idle();
            s.reset      = ($urandom_range(0, 79) == 0);
            s.pc_load    = ($urandom_range(0, 15) == 0);
            s.pc_in      = int'($urandom_range(0, 65535));
            s.imem_we    = ($urandom_range(0, 3) == 0);
            s.imem_waddr = $urandom_range(0, 1) ? (m_pc + int'($urandom_range(0, 2))) % 256
                                                : int'($urandom_range(0, 255));
            s.imem_wdata = int'($urandom_range(0, 65535));
            s.reg_dest   = $urandom_range(0, 1) == 1;
            s.alu_src    = $urandom_range(0, 1) == 1;
            s.mem_to_reg = $urandom_range(0, 1) == 1;
            s.reg_write  = $urandom_range(0, 3) != 0;
            s.mem_read   = $urandom_range(0, 1) == 1;
            s.mem_write  = $urandom_range(0, 2) == 0;
            s.alu_op     = int'($urandom_range(0, 3));
            if (s.mem_read) begin
                model_eval(s, e);
                if (!m_dw[e.alu % 256]) s.mem_read = 0;
            end
            step(s, 1, 0, 0, -1);
        end

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath16_core.md
Name: datapath16_core

Overview:
- Single-cycle 16-bit datapath: PC, 256x16 instruction memory, 8x16 register file, 16-bit ALU, 256x16 data memory, and write-back muxes.
- An external control unit decodes `opcode` and drives the control inputs. This block only executes.
- Bench/loader port fills instruction memory.

Parameters:
- IMEM_DEPTH, 256, instruction words; address = pc[7:0].
- DMEM_DEPTH, 256, data words; address = alu_result[7:0].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pc_load  in  1  load pc_in instead of incrementing.
- pc_in  in  16  PC load value.
- imem_we  in  1  instruction memory write enable.
- imem_waddr  in  8  instruction write address.
- imem_wdata  in  16  instruction write data.
- reg_dest  in  1  destination select: 1 = rd, 0 = rt.
- alu_src  in  1  ALU B select: 1 = sign-extended imm, 0 = rt data.
- mem_to_reg  in  1  write-back select: 1 = dmem read, 0 = ALU result.
- reg_write  in  1  register file write enable.
- mem_read  in  1  dmem read enable (read data = 0 when low).
- mem_write  in  1  dmem write enable.
- alu_op  in  2  00 add, 01 sub, 10 use funct, 11 add.
- opcode  out  2  instr[15:14].
- pc  out  16  current PC.
- instr  out  16  current instruction.
- alu_result  out  16  ALU output.
- zero  out  1  alu_result == 0.
- overflow  out  1  signed overflow of add/sub.
- wb_data  out  16  write-back value.

Behaviour:
- Instruction fields:
  - opcode = [15:14], rs = [13:11], rt = [10:8], rd = [7:5], funct = [4:0], imm = [7:0].
  - imm is sign-extended to 16 bits, {8{imm[7]}, imm}.
- PC, on each rising clk edge, in priority order:
  - reset → 0.
  - else pc_load → pc_in.
  - else pc + 1, wrapping 0xFFFF → 0.
- Instruction memory:
  - Read is combinational: instr = imem[pc[7:0]].
  - Write is synchronous on imem_we.
  - A write to the currently addressed word appears in instr after the edge.
  - Contents are not cleared by reset.
- Register file:
  - 8x16, two combinational read ports (rs, rt), one synchronous write port.
  - Write address = reg_dest ? rd : rt.
  - R0 always reads 0; writes to R0 are ignored.
  - Reset clears R1..R7 to 0.
  - Read-during-write returns the old value; the new value is visible next cycle.
- ALU:
  - A = rs data; B = alu_src ? sign-extended imm : rt data.
  - Effective op: alu_op 00 add, 01 sub, 10 from funct.
  - funct codes: 0 add, 1 sub, 2 AND, 3 OR, 4 SLT (signed; result = 1 or 0), other codes add.
  - Arithmetic is 16-bit modulo.
  - overflow is asserted only for add/sub, when the operand signs and the result sign satisfy the two's-complement overflow rule; 0 for other ops.
  - zero = (alu_result == 0).
  - All ALU outputs are purely combinational.
- Data memory:
  - Synchronous write of rt data to dmem[alu_result[7:0]] when mem_write.
  - Combinational read, gated by mem_read.
  - Not cleared by reset.
- Write-back: wb_data = mem_to_reg ? dmem read : alu_result.
- Reset behaviour:
  - Suppresses register and dmem writes in the same cycle.
  - Outputs after reset: pc = 0; instr = imem[0]; all other outputs follow combinationally from those.
- Simultaneous events:
  - pc_load with reset: reset wins.
  - imem_we is independent of reset and execution.
- Latency: one instruction per cycle; write-back takes effect at the edge that ends the instruction.

Decomposition:
- Shared package: field bit positions, ALU_OP_ADD/SUB/FUNCT, FUNCT_ADD/SUB/AND/OR/SLT constants, width 16, reg count 8.
- Sub-modules: alu16 (combinational), regfile8x16, imem/dmem arrays; top wires them with the muxes.

Test Plan:
- Reset → pc = 0; after reset deasserts, pc counts 0,1,2,3. pc_load with pc_in = 0x0010 → next pc = 0x0010.
- Load imem[0] = 0x4105, imem[1] = 0x42FE, driving reg_dest 0, alu_src 1, alu_op 00, reg_write 1 → R1 = 0x0005, R2 = 0xFFFE; wb_data shows these values.
- R-type: 0x0A60 funct add → R3 = 0x0003; 0x0A81 sub → R4 = 0x0007; 0x11A4 slt → R5 = 0x0001. Controls: reg_dest 1, alu_src 0, alu_op 10.
- Overflow: R1 = 0x7FFF, add imm 1 → alu_result 0x8000, overflow = 1. Sub R1,R1 → zero = 1, overflow = 0.
- Memory: sw with R1 = 5, rt data 0x1234, imm 3 → dmem[8] = 0x1234. lw with mem_read = 1, mem_to_reg = 1 → rt = 0x1234. With mem_read = 0 → wb_data = 0.
- Write to R0 (I-type, rt = 0, imm 7) → R0 still reads 0. Mid-program reset → pc = 0, R1..R7 = 0, imem preserved.
